// File: rtl/multicycle_control_fsm_if.sv
// Control/status bundle between the RV32I multi-cycle control FSM and its datapath.
// The master modport is the controller; the slave modport is the datapath side.
interface multicycle_control_fsm_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       lt;
    logic       ltu;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic       illegal;
    logic [3:0] state_o;

    modport master (
        input  opcode, funct3, zero, lt, ltu, mem_ready,
        output pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a,
               alu_src_b, alu_op, result_src, imm_src, illegal, state_o
    );

    modport slave (
        output opcode, funct3, zero, lt, ltu, mem_ready,
        input  pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a,
               alu_src_b, alu_op, result_src, imm_src, illegal, state_o
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the RV32I multi-cycle datapath: sequences fetch/decode/execute/
// memory/write-back, drives register enables and mux selects, stalls on mem_ready.
//
// state    | meaning
// FETCH    | read instruction at PC, load IR/OldPC and PC+4 when memory ready
// DECODE   | ALUOut <= OldPC + imm, dispatch on opcode
// MEMADR   | ALUOut <= rs1 + imm for load/store
// MEMREAD  | read data memory, wait for ready
// MEMWB    | write loaded data to register file
// MEMWRITE | write data memory, strobe held until ready
// EXECR    | register-register ALU op
// EXECI    | register-immediate ALU op
// ALUWB    | write ALUOut to register file
// BRANCH   | compare rs1/rs2, PC <= ALUOut when taken
// JAL      | PC <= ALUOut target, ALU computes OldPC + 4 link
// JALR     | ALUOut <= rs1 + imm target
// LUI      | write ImmExt to register file
// AUIPC    | ALUOut <= OldPC + imm
// ILLEGAL  | trapped, absorbing until reset
module multicycle_control_fsm (
    input  logic                           clk,
    input  logic                           rst,
    multicycle_control_fsm_if.master       ctrl
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12,
        S_AUIPC    = 4'd13,
        S_ILLEGAL  = 4'd15
    } state_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    state_e state_q, state_d;
    logic   taken;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (ctrl.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (ctrl.opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_I:              state_d = S_EXECI;
                    OP_BR:             state_d = (ctrl.funct3[2:1] == 2'b01) ? S_ILLEGAL : S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_d = (ctrl.opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (ctrl.mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (ctrl.mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_JAL;
            S_LUI:      state_d = S_FETCH;
            S_AUIPC:    state_d = S_ALUWB;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_ILLEGAL;
        endcase
    end

    // funct3 010/011 never reach BRANCH, so they need no entry here
    always_comb begin
        taken = 1'b0;
        case (ctrl.funct3)
            3'b000:  taken = ctrl.zero;
            3'b001:  taken = ~ctrl.zero;
            3'b100:  taken = ctrl.lt;
            3'b101:  taken = ~ctrl.lt;
            3'b110:  taken = ctrl.ltu;
            3'b111:  taken = ~ctrl.ltu;
            default: taken = 1'b0;
        endcase
    end

    // Everything is gated by rst so outputs drop to 0 the moment reset asserts
    always_comb begin
        ctrl.pc_write   = 1'b0;
        ctrl.ir_write   = 1'b0;
        ctrl.reg_write  = 1'b0;
        ctrl.mem_write  = 1'b0;
        ctrl.adr_src    = 1'b0;
        ctrl.alu_src_a  = 2'b00;
        ctrl.alu_src_b  = 2'b00;
        ctrl.alu_op     = 2'b00;
        ctrl.result_src = 2'b00;
        ctrl.imm_src    = 3'b000;
        ctrl.illegal    = 1'b0;
        ctrl.state_o    = 4'd0;
        if (rst) begin
            ctrl.state_o = state_q;
            case (ctrl.opcode)
                OP_STORE:         ctrl.imm_src = 3'b001;
                OP_BR:            ctrl.imm_src = 3'b010;
                OP_JAL:           ctrl.imm_src = 3'b011;
                OP_LUI, OP_AUIPC: ctrl.imm_src = 3'b100;
                default:          ctrl.imm_src = 3'b000;
            endcase
            case (state_q)
                S_FETCH: begin
                    ctrl.alu_src_b  = 2'b10;
                    ctrl.result_src = 2'b10;
                    ctrl.ir_write   = ctrl.mem_ready;
                    ctrl.pc_write   = ctrl.mem_ready;
                end
                S_DECODE, S_AUIPC: begin
                    ctrl.alu_src_a = 2'b01;
                    ctrl.alu_src_b = 2'b01;
                end
                S_MEMADR, S_JALR: begin
                    ctrl.alu_src_a = 2'b10;
                    ctrl.alu_src_b = 2'b01;
                end
                S_MEMREAD:  ctrl.adr_src = 1'b1;
                S_MEMWB: begin
                    ctrl.result_src = 2'b01;
                    ctrl.reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    ctrl.adr_src   = 1'b1;
                    ctrl.mem_write = 1'b1;
                end
                S_EXECR: begin
                    ctrl.alu_src_a = 2'b10;
                    ctrl.alu_op    = 2'b10;
                end
                S_EXECI: begin
                    ctrl.alu_src_a = 2'b10;
                    ctrl.alu_src_b = 2'b01;
                    ctrl.alu_op    = 2'b10;
                end
                S_ALUWB:    ctrl.reg_write = 1'b1;
                S_BRANCH: begin
                    ctrl.alu_src_a = 2'b10;
                    ctrl.alu_op    = 2'b01;
                    ctrl.pc_write  = taken;
                end
                S_JAL: begin
                    ctrl.alu_src_a = 2'b01;
                    ctrl.alu_src_b = 2'b10;
                    ctrl.pc_write  = 1'b1;
                end
                S_LUI: begin
                    ctrl.result_src = 2'b11;
                    ctrl.reg_write  = 1'b1;
                end
                S_ILLEGAL:  ctrl.illegal = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control unit of the RV32I multi-cycle datapath. It sequences every instruction through fetch, decode, execute, memory and write-back states. It drives the write enables of all enable-gated datapath registers: ir_write loads the instruction and old-PC register pair, and pc_write loads the PC. It also drives the datapath mux selects and stalls on a single-bit memory ready handshake.

## Interface
- No parameters.
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low
- opcode  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- zero  in  1  ALU result == 0
- lt  in  1  signed rs1 < rs2, from current-cycle ALU subtract
- ltu  in  1  unsigned rs1 < rs2
- mem_ready  in  1  memory completes access this cycle
- pc_write  out  1  PC register enable
- ir_write  out  1  instruction/old-PC register-pair enable
- reg_write  out  1  register-file write enable
- mem_write  out  1  data memory write strobe
- adr_src  out  1  0 = PC, 1 = Result
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1
- alu_src_b  out  2  00 rs2, 01 ImmExt, 10 constant 4
- alu_op  out  2  00 add, 01 branch subtract, 10 funct-decoded
- result_src  out  2  00 ALUOut, 01 mem Data, 10 ALUResult, 11 ImmExt
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- illegal  out  1  unsupported opcode or branch funct3 trapped
- state_o  out  4  current state encoding (debug)

## Operation
- Moore FSM. State encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5
  - EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11
  - LUI 12, AUIPC 13, ILLEGAL 15
- Any output not listed for a state is 0.
- imm_src is combinational from opcode in every state:
  - load / OP-IMM / JALR → 000
  - store → 001
  - branch → 010
  - JAL → 011
  - LUI / AUIPC → 100
  - other → 000
- FETCH: adr_src=0, a=00, b=10, alu_op=00, result_src=10.
  - If mem_ready=1: ir_write=1, pc_write=1 (PC←PC+4); next DECODE.
  - If mem_ready=0: both enables 0; stay in FETCH.
- DECODE: a=01, b=01, alu_op=00 (ALUOut←OldPC+imm). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH, or ILLEGAL when funct3 is 010 or 011
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - else → ILLEGAL
- MEMADR: a=10, b=01, alu_op=00. Load → MEMREAD; store → MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Stays until mem_ready=1, then MEMWB.
- MEMWB: result_src=01, reg_write=1 → FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1, held until mem_ready=1 → FETCH.
- EXECR: a=10, b=00, alu_op=10 → ALUWB.
- EXECI: a=10, b=01, alu_op=10 → ALUWB.
- ALUWB: result_src=00, reg_write=1 → FETCH.
- BRANCH: a=10, b=00, alu_op=01, result_src=00; → FETCH.
  - pc_write = taken, where taken by funct3 is: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1 (PC←ALUOut target; ALU computes link OldPC+4) → ALUWB.
- JALR: a=10, b=01, alu_op=00 (target rs1+imm into ALUOut) → JAL.
- LUI: result_src=11, reg_write=1 → FETCH.
- AUIPC: a=01, b=01, alu_op=00 → ALUWB.
- ILLEGAL: illegal=1, all enables 0. Absorbing until reset.

## Timing
- While rst=0:
  - state=FETCH.
  - All outputs forced to 0, including enables, selects, illegal and state_o.
- After rst rises, FETCH outputs are valid before the first rising edge.
- Cycles per instruction with mem_ready always 1:
  - branch 3, LUI 3
  - R/I-ALU 4, store 4, JAL 4, AUIPC 4
  - load 5, JALR 5
- Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- Enables are never asserted during a stalled FETCH.
- mem_write stays asserted through a MEMWRITE stall.
- Reset asserted mid-instruction: state goes to FETCH and outputs go to 0 immediately (asynchronous). No partial write occurs after assertion.
- Flags zero/lt/ltu are sampled only in BRANCH, as a same-cycle combinational dependency.

## Test plan
- ADD x3,x1,x2 (opcode 0110011), mem_ready=1 → state_o 0,1,6,8,0; reg_write=1 only in cycle 4; ir_write=1 only in cycle 1.
- LW with mem_ready=0 for 2 cycles in MEMREAD → state_o 0,1,2,3,3,3,4,0; reg_write=1 with result_src=01 in MEMWB.
- BNE (funct3 001) twice: first with zero=1, then with zero=0 → pc_write=0 then pc_write=1 in BRANCH; both take 3 cycles.
- JALR → 0,1,11,10,8,0; pc_write=1 in JAL with result_src=00; reg_write=1 in ALUWB.
- Opcode 1111111, then branch with funct3 010 → illegal=1, state_o=15 held for 10 cycles; rst low → all outputs 0; rst high → FETCH.
- rst asserted mid-MEMWRITE → mem_write drops without a clock edge; after release, state_o=0.
